fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Controller that sequences the fetch stage's PC and instruction-word assembly.
//  - Loads the 32-bit reset vector from instruction memory after reset.
//  - Assembles 16-bit instructions and 16+16-bit instruction/immediate pairs.
//  - Applies stall, jump redirect and interrupt-vector entry with fixed priority.
//  - Sits between the word-addressed instruction memory and the IF/ID register.
// PARAMETERS
//  PC_W          32  PC width (word address)
//  INSTR_W       16  instruction memory word width
//  RESET_VEC     0   address of reset vector (hi word at RESET_VEC, lo at +1)
//  INT_VEC       2   address of interrupt vector (hi word at INT_VEC, lo at +1)
//  IMM_BIT       0   instruction bit that, when 1, marks a following immediate word
// PORTS
//  clk               in   1        clock; all state updates on rising edge
//  rst               in   1        asynchronous, active-high reset
//  stall             in   1        hazard stall; freeze PC, state and outputs
//  jumpBit           in   1        redirect request from later stage (1-cycle pulse)
//  branchIR          in   PC_W     redirect target, valid with jumpBit
//  interruptBit      in   1        interrupt request (pulse or level)
//  instrWord         in   INSTR_W  memory data at address pc (combinational read)
//  pc                out  PC_W     current fetch address to instruction memory
//  finalInstruction  out  INSTR_W  registered instruction to IF/ID
//  immediate         out  INSTR_W  registered immediate; valid when immValid
//  fetchValid        out  1        finalInstruction valid this cycle (1-cycle pulse)
//  immValid          out  1        immediate valid this cycle (only with fetchValid)
//  intAck            out  1        1-cycle pulse on interrupt entry
//  savedPc           out  PC_W     return PC captured on intAck; held until next intAck
// BEHAVIOUR
//  States: VEC_HI, VEC_LO, RUN, IMM.
//  Reset (async): state=VEC_HI, pc=RESET_VEC; all other outputs 0; intPending=0.
//  VEC_HI: vecHi<=instrWord; pc<=pc+1; ->VEC_LO. No fetchValid.
//  VEC_LO: pc<={vecHi,instrWord}; ->RUN. No fetchValid.
//  RUN, instrWord[IMM_BIT]=0:
//    finalInstruction<=instrWord; fetchValid<=1; immValid<=0; pc<=pc+1.
//  RUN, instrWord[IMM_BIT]=1:
//    held<=instrWord; pc<=pc+1; ->IMM; fetchValid<=0.
//  IMM: finalInstruction<=held; immediate<=instrWord; fetchValid<=1; immValid<=1;
//    pc<=pc+1; ->RUN.
//  Latency: one cycle from pc presentation to fetchValid; 2 cycles for an imm pair.
//  fetchValid, immValid and intAck are 0 in every cycle not listed above.
//  Priority per cycle: rst > jumpBit > stall > interrupt > sequential.
//  Jump redirect:
//    - In RUN or IMM: pc<=branchIR; ->RUN; fetchValid<=0; held word dropped.
//    - Taken even while stall=1.
//    - Ignored in VEC_HI/VEC_LO.
//  stall=1 (no jump): pc, state, held, finalInstruction, immediate hold;
//    fetchValid, immValid, intAck drive 0.
//  Interrupt latching: interruptBit sets intPending on any edge, including
//    during stall and in vector states; cleared on intAck.
//  Interrupt service: only in RUN, no stall, no jump, intPending=1:
//    - savedPc<=pc; intAck<=1; intPending<=0; pc<=INT_VEC; ->VEC_HI; fetchValid<=0.
//    - Never serviced in IMM, so an instruction/immediate pair is never split.
//  Jump and pending interrupt in same cycle: jump taken; interrupt serviced on
//    the next eligible RUN cycle, with savedPc = the jump target.
//  Arithmetic: pc+1 wraps modulo 2^PC_W (0xFFFFFFFF -> 0x0).
//  Reset mid-operation (any state): immediate return to reset values;
//    pending interrupt and held word lost.
// TESTING
//  T1 M[0]=0x0000, M[1]=0x0010, rst pulse -> pc 0,1 then 0x10; first fetchValid 3 cycles after rst release.
//  T2 RUN at 0x10, M[0x10]=0x3811, M[0x11]=0x0004 -> one fetchValid/immValid pulse, final=0x3811, imm=0x0004, pc=0x12.
//  T3 stall high 3 cycles mid-sequence -> pc and outputs frozen, fetchValid=0; resumes identically after.
//  T4 jumpBit with branchIR=0x40 while in IMM (and again under stall) -> pc=0x40 next cycle, no fetchValid, held word dropped.
//  T5 interruptBit pulse during IMM at pc 0x11 -> pair completes, then intAck, savedPc=0x12, pc loads M[2]:M[3].
//  T6 jumpBit+interrupt same cycle to 0x80, then rst asserted in VEC_LO -> pc=0x80, savedPc=0x80; rst returns to VEC_HI, pc=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: reset/interrupt vector load, 16-bit instruction and
// instruction+immediate assembly, with jump > stall > interrupt priority.
module fetch_sequencer #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned INT_VEC   = 2,
    parameter int unsigned IMM_BIT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jumpBit,
    input  logic [PC_W-1:0]    branchIR,
    input  logic               interruptBit,
    input  logic [INSTR_W-1:0] instrWord,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] finalInstruction,
    output logic [INSTR_W-1:0] immediate,
    output logic               fetchValid,
    output logic               immValid,
    output logic               intAck,
    output logic [PC_W-1:0]    savedPc
);

    typedef enum logic [1:0] {VEC_HI, VEC_LO, RUN, IMM} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    saved_q, saved_d;
    logic [INSTR_W-1:0] vec_hi_q, vec_hi_d;
    logic [INSTR_W-1:0] held_q, held_d;
    logic [INSTR_W-1:0] final_q, final_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic               fv_q, fv_d;
    logic               iv_q, iv_d;
    logic               ack_q, ack_d;
    logic               pend_q, pend_d;

    logic               do_jump, do_stall, do_int;
    logic               imm_flag;
    logic [PC_W-1:0]    pc_inc;

    // Exclusive per-cycle actions in priority order
    assign do_jump  = jumpBit && (state_q == RUN || state_q == IMM);
    assign do_stall = stall && !do_jump;
    assign do_int   = !do_jump && !stall && state_q == RUN && pend_q;
    assign imm_flag = instrWord[IMM_BIT];
    assign pc_inc   = pc_q + PC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= VEC_HI;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            do_jump:  state_d = RUN;
            do_stall: state_d = state_q;
            do_int:   state_d = VEC_HI;
            default: begin
                unique case (state_q)
                    VEC_HI:  state_d = VEC_LO;
                    VEC_LO:  state_d = RUN;
                    RUN:     state_d = imm_flag ? IMM : RUN;
                    IMM:     state_d = RUN;
                    default: state_d = VEC_HI;
                endcase
            end
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        saved_d  = saved_q;
        vec_hi_d = vec_hi_q;
        held_d   = held_q;
        final_d  = final_q;
        imm_d    = imm_q;
        fv_d     = 1'b0;
        iv_d     = 1'b0;
        ack_d    = 1'b0;
        pend_d   = pend_q | interruptBit;
        unique case (1'b1)
            do_jump:  pc_d = branchIR;
            do_stall: pc_d = pc_q;
            do_int: begin
                saved_d = pc_q;
                ack_d   = 1'b1;
                pend_d  = interruptBit;
                pc_d    = PC_W'(INT_VEC);
            end
            default: begin
                unique case (state_q)
                    VEC_HI: begin
                        vec_hi_d = instrWord;
                        pc_d     = pc_inc;
                    end
                    VEC_LO: pc_d = PC_W'({vec_hi_q, instrWord});
                    RUN: begin
                        pc_d = pc_inc;
                        if (imm_flag) begin
                            held_d = instrWord;
                        end else begin
                            final_d = instrWord;
                            fv_d    = 1'b1;
                        end
                    end
                    IMM: begin
                        final_d = held_q;
                        imm_d   = instrWord;
                        fv_d    = 1'b1;
                        iv_d    = 1'b1;
                        pc_d    = pc_inc;
                    end
                    default: pc_d = pc_q;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= PC_W'(RESET_VEC);
            saved_q  <= '0;
            vec_hi_q <= '0;
            held_q   <= '0;
            final_q  <= '0;
            imm_q    <= '0;
            fv_q     <= 1'b0;
            iv_q     <= 1'b0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            saved_q  <= saved_d;
            vec_hi_q <= vec_hi_d;
            held_q   <= held_d;
            final_q  <= final_d;
            imm_q    <= imm_d;
            fv_q     <= fv_d;
            iv_q     <= iv_d;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
        end
    end

    assign pc               = pc_q;
    assign finalInstruction = final_q;
    assign immediate        = imm_q;
    assign fetchValid       = fv_q;
    assign immValid         = iv_q;
    assign intAck           = ack_q;
    assign savedPc          = saved_q;

endmodule
